// File: rtl/sraml_rr_arbiter.sv
// sraml_rr_arbiter: merges NCH SRAM-like masters onto one SRAM-like port.
// Round-robin grant, locked while a request waits for acceptance. Responses
// come back in order and are steered to their channel by an ID FIFO.
module sraml_rr_arbiter #(
  parameter int NCH   = 2,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           s_req,
  input  logic [NCH-1:0]           s_wr,
  input  logic [2*NCH-1:0]         s_size,
  input  logic [AW*NCH-1:0]        s_addr,
  input  logic [DW*NCH-1:0]        s_wdata,
  output logic [NCH-1:0]           s_addr_ok,
  output logic [NCH-1:0]           s_data_ok,
  output logic [DW-1:0]            s_rdata,
  output logic                     m_req,
  output logic                     m_wr,
  output logic [1:0]               m_size,
  output logic [AW-1:0]            m_addr,
  output logic [DW-1:0]            m_wdata,
  input  logic                     m_addr_ok,
  input  logic                     m_data_ok,
  input  logic [DW-1:0]            m_rdata,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     proto_err
);

  localparam int IDW = $clog2(NCH);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;

  typedef enum logic {
    LOCK_IDLE,
    LOCK_HELD
  } lockState_e;

  lockState_e        lockState_q, lockState_d;
  logic [IDW-1:0]    grant_q;
  logic [IDW-1:0]    lastGrant_q;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     wrPtr_q, rdPtr_q;
  logic [IDW-1:0]    fifo_q [DEPTH];
  logic              protoErr_q;

  logic [IDW-1:0]    arbGrant;
  logic [IDW-1:0]    grant;
  logic [IDW-1:0]    headId;
  logic              full;
  logic              accept;
  logic              respValid;

  // Round-robin search starting just after the last accepted channel
  always_comb begin
    int idx;
    logic found;
    logic [IDW-1:0] idxNarrow;
    arbGrant  = lastGrant_q;
    found     = 1'b0;
    idx       = 0;
    idxNarrow = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx       = (int'(lastGrant_q) + k) % NCH;
      idxNarrow = IDW'(idx);
      if (!found && s_req[idxNarrow]) begin
        arbGrant = idxNarrow;
        found    = 1'b1;
      end
    end
  end

  // Grant selection, request forwarding and per-channel handshake steering
  always_comb begin
    grant     = (lockState_q == LOCK_HELD) ? grant_q : arbGrant;
    full      = (count_q == CW'(DEPTH));
    m_req     = s_req[grant] & ~full;
    m_wr      = s_wr[grant];
    m_size    = s_size[2*int'(grant) +: 2];
    m_addr    = s_addr[AW*int'(grant) +: AW];
    m_wdata   = s_wdata[DW*int'(grant) +: DW];
    accept    = m_req & m_addr_ok;
    respValid = m_data_ok & (count_q != '0);
    headId    = fifo_q[rdPtr_q];
    s_addr_ok = '0;
    s_data_ok = '0;
    if (accept) begin
      s_addr_ok[grant] = 1'b1;
    end
    if (respValid) begin
      s_data_ok[headId] = 1'b1;
    end
    s_rdata     = m_rdata;
    outstanding = count_q;
    proto_err   = protoErr_q;
    count_d     = count_q + CW'(accept) - CW'(respValid);
  end

  // Lock next state: hold the grant while the downstream stalls an offered request
  always_comb begin
    lockState_d = lockState_q;
    if (m_req && !m_addr_ok) begin
      lockState_d = LOCK_HELD;
    end else if (accept) begin
      lockState_d = LOCK_IDLE;
    end
  end

  // Control state: lock, grant history, in-flight count, FIFO pointers, error flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      lockState_q <= LOCK_IDLE;
      grant_q     <= '0;
      lastGrant_q <= IDW'(NCH - 1);
      count_q     <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      protoErr_q  <= 1'b0;
    end else begin
      lockState_q <= lockState_d;
      grant_q     <= grant;
      count_q     <= count_d;
      if (accept) begin
        lastGrant_q <= grant;
        wrPtr_q     <= wrPtr_q + PW'(1);
      end
      if (respValid) begin
        rdPtr_q <= rdPtr_q + PW'(1);
      end
      if (m_data_ok && (count_q == '0)) begin
        protoErr_q <= 1'b1;
      end
    end
  end

  // Channel-ID storage; contents are only meaningful between wr and rd pointers
  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_q[wrPtr_q] <= grant;
    end
  end

endmodule

// File: tb/tb_sraml_rr_arbiter.sv
// tb_sraml_rr_arbiter: directed stimulus with a scoreboard. Expected accepts
// and responses are queued as stimulus is issued; a negedge monitor pops and
// compares whenever the arbiter raises s_addr_ok or s_data_ok.
module tb_sraml_rr_arbiter;

  localparam int NCH   = 2;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  localparam logic [31:0] ADDR0  = 32'h0000_1000;
  localparam logic [31:0] ADDR1  = 32'h8000_2000;
  localparam logic [31:0] WDATA0 = 32'h0A0A_0000;
  localparam logic [31:0] WDATA1 = 32'h1B1B_1111;

  typedef struct {
    logic [1:0]  mask;
    logic [31:0] data;
  } exp_t;

  logic                   clk;
  logic                   rst;
  logic [NCH-1:0]         s_req;
  logic [NCH-1:0]         s_wr;
  logic [2*NCH-1:0]       s_size;
  logic [AW*NCH-1:0]      s_addr;
  logic [DW*NCH-1:0]      s_wdata;
  logic [NCH-1:0]         s_addr_ok;
  logic [NCH-1:0]         s_data_ok;
  logic [DW-1:0]          s_rdata;
  logic                   m_req;
  logic                   m_wr;
  logic [1:0]             m_size;
  logic [AW-1:0]          m_addr;
  logic [DW-1:0]          m_wdata;
  logic                   m_addr_ok;
  logic                   m_data_ok;
  logic [DW-1:0]          m_rdata;
  logic [$clog2(DEPTH):0] outstanding;
  logic                   proto_err;

  exp_t expAcceptQ[$];
  exp_t expRespQ[$];
  int   vectors     = 0;
  int   miscompares = 0;

  sraml_rr_arbiter #(
    .NCH   (NCH),
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_req       (s_req),
    .s_wr        (s_wr),
    .s_size      (s_size),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_addr_ok   (s_addr_ok),
    .s_data_ok   (s_data_ok),
    .s_rdata     (s_rdata),
    .m_req       (m_req),
    .m_wr        (m_wr),
    .m_size      (m_size),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_addr_ok   (m_addr_ok),
    .m_data_ok   (m_data_ok),
    .m_rdata     (m_rdata),
    .outstanding (outstanding),
    .proto_err   (proto_err)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Runaway guard so the bench always terminates
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] req, input logic addrOk, input logic dataOk,
                               input logic [31:0] rdata);
    s_req     = req;
    m_addr_ok = addrOk;
    m_data_ok = dataOk;
    m_rdata   = rdata;
  endtask

  task automatic pushAccept(input int ch, input logic [31:0] addr);
    exp_t e;
    e.mask     = '0;
    e.mask[ch] = 1'b1;
    e.data     = addr;
    expAcceptQ.push_back(e);
  endtask

  task automatic pushResp(input int ch, input logic [31:0] data);
    exp_t e;
    e.mask     = '0;
    e.mask[ch] = 1'b1;
    e.data     = data;
    expRespQ.push_back(e);
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic waitSample;
    @(negedge clk);
  endtask

  // Monitor: every handshake the arbiter presents must match the next queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (s_addr_ok != '0) begin
      if (expAcceptQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected accept: got s_addr_ok=0x%0h, expected none", s_addr_ok);
      end else begin
        e = expAcceptQ.pop_front();
        checkOutput("accept s_addr_ok", 32'(s_addr_ok), 32'(e.mask));
        checkOutput("accept m_addr", m_addr, e.data);
      end
    end
    if (s_data_ok != '0) begin
      if (expRespQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected response: got s_data_ok=0x%0h, expected none", s_data_ok);
      end else begin
        e = expRespQ.pop_front();
        checkOutput("resp s_data_ok", 32'(s_data_ok), 32'(e.mask));
        checkOutput("resp s_rdata", s_rdata, e.data);
      end
    end
  end

  // Directed stimulus sequence
  initial begin
    logic [31:0] addr;
    rst     = 1'b0;
    s_wr    = 2'b10;
    s_size  = {2'd2, 2'd1};
    s_addr  = {ADDR1, ADDR0};
    s_wdata = {WDATA1, WDATA0};
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);

    // Reset state
    repeat (2) nextCycle;
    waitSample;
    checkOutput("reset outstanding", 32'(outstanding), 32'd0);
    checkOutput("reset m_req", 32'(m_req), 32'd0);
    checkOutput("reset proto_err", 32'(proto_err), 32'd0);
    checkOutput("reset s_addr_ok", 32'(s_addr_ok), 32'd0);
    checkOutput("reset s_data_ok", 32'(s_data_ok), 32'd0);
    nextCycle;
    rst = 1'b1;

    // 1) both channels request continuously; grants alternate 0,1,0,1...
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        applyStimulus(2'b11, 1'b1, 1'b1, 32'hD100_0000 + 32'(i));
        pushResp((i - 1) % 2, 32'hD100_0000 + 32'(i));
      end else begin
        applyStimulus(2'b11, 1'b1, 1'b0, 32'h0);
      end
      pushAccept(i % 2, ((i % 2) == 0) ? ADDR0 : ADDR1);
      nextCycle;
    end
    applyStimulus(2'b00, 1'b0, 1'b1, 32'hD100_0006);
    pushResp(1, 32'hD100_0006);
    nextCycle;
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
    waitSample;
    checkOutput("t1 outstanding drained", 32'(outstanding), 32'd0);
    nextCycle;

    // 2) ch1 stalled three cycles while ch0 joins; ch1 must stay granted
    applyStimulus(2'b10, 1'b0, 1'b0, 32'h0);
    waitSample;
    checkOutput("t2 m_req stalled", 32'(m_req), 32'd1);
    checkOutput("t2 m_addr ch1", m_addr, ADDR1);
    checkOutput("t2 m_wr ch1", 32'(m_wr), 32'd1);
    checkOutput("t2 m_size ch1", 32'(m_size), 32'd2);
    checkOutput("t2 m_wdata ch1", m_wdata, WDATA1);
    nextCycle;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(2'b11, 1'b0, 1'b0, 32'h0);
      waitSample;
      checkOutput("t2 m_addr held", m_addr, ADDR1);
      nextCycle;
    end
    applyStimulus(2'b11, 1'b1, 1'b0, 32'h0);
    pushAccept(1, ADDR1);
    nextCycle;
    applyStimulus(2'b01, 1'b1, 1'b0, 32'h0);
    pushAccept(0, ADDR0);
    waitSample;
    checkOutput("t2 m_wr ch0", 32'(m_wr), 32'd0);
    checkOutput("t2 m_size ch0", 32'(m_size), 32'd1);
    nextCycle;
    applyStimulus(2'b00, 1'b0, 1'b1, 32'hD200_0001);
    pushResp(1, 32'hD200_0001);
    nextCycle;
    applyStimulus(2'b00, 1'b0, 1'b1, 32'hD200_0002);
    pushResp(0, 32'hD200_0002);
    nextCycle;
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
    waitSample;
    checkOutput("t2 outstanding drained", 32'(outstanding), 32'd0);
    nextCycle;

    // 3) fill to DEPTH, confirm back-pressure and release one cycle after a response
    for (int i = 0; i < DEPTH; i++) begin
      addr = 32'h0000_3000 + 32'(4 * i);
      s_addr[31:0] = addr;
      applyStimulus(2'b01, 1'b1, 1'b0, 32'h0);
      pushAccept(0, addr);
      nextCycle;
    end
    applyStimulus(2'b01, 1'b1, 1'b0, 32'h0);
    waitSample;
    checkOutput("t3 outstanding full", 32'(outstanding), 32'd4);
    checkOutput("t3 m_req blocked", 32'(m_req), 32'd0);
    nextCycle;
    applyStimulus(2'b01, 1'b1, 1'b1, 32'hD300_0000);
    pushResp(0, 32'hD300_0000);
    waitSample;
    checkOutput("t3 m_req blocked during resp", 32'(m_req), 32'd0);
    nextCycle;
    s_addr[31:0] = 32'h0000_3010;
    applyStimulus(2'b01, 1'b1, 1'b0, 32'h0);
    pushAccept(0, 32'h0000_3010);
    waitSample;
    checkOutput("t3 outstanding after resp", 32'(outstanding), 32'd3);
    checkOutput("t3 m_req reasserted", 32'(m_req), 32'd1);
    nextCycle;
    for (int i = 1; i <= DEPTH; i++) begin
      applyStimulus(2'b00, 1'b0, 1'b1, 32'hD300_0000 + 32'(i));
      pushResp(0, 32'hD300_0000 + 32'(i));
      nextCycle;
    end
    s_addr[31:0] = ADDR0;
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
    waitSample;
    checkOutput("t3 outstanding drained", 32'(outstanding), 32'd0);
    nextCycle;

    // 4) accept ch0 while the earlier ch1 request is answered
    applyStimulus(2'b10, 1'b1, 1'b0, 32'h0);
    pushAccept(1, ADDR1);
    nextCycle;
    applyStimulus(2'b01, 1'b1, 1'b1, 32'hD400_0001);
    pushAccept(0, ADDR0);
    pushResp(1, 32'hD400_0001);
    waitSample;
    checkOutput("t4 s_addr_ok", 32'(s_addr_ok), 32'h1);
    checkOutput("t4 s_data_ok", 32'(s_data_ok), 32'h2);
    nextCycle;
    applyStimulus(2'b00, 1'b0, 1'b1, 32'hD400_0002);
    pushResp(0, 32'hD400_0002);
    waitSample;
    checkOutput("t4 outstanding unchanged", 32'(outstanding), 32'd1);
    nextCycle;
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
    waitSample;
    checkOutput("t4 outstanding drained", 32'(outstanding), 32'd0);
    nextCycle;

    // 5) stray response with nothing in flight sets a sticky error
    rst = 1'b0;
    nextCycle;
    rst = 1'b1;
    waitSample;
    checkOutput("t5 proto_err clear", 32'(proto_err), 32'd0);
    nextCycle;
    applyStimulus(2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF);
    waitSample;
    checkOutput("t5 no s_data_ok", 32'(s_data_ok), 32'd0);
    nextCycle;
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
    waitSample;
    checkOutput("t5 proto_err set", 32'(proto_err), 32'd1);
    checkOutput("t5 outstanding stays 0", 32'(outstanding), 32'd0);
    repeat (3) nextCycle;
    waitSample;
    checkOutput("t5 proto_err sticky", 32'(proto_err), 32'd1);
    nextCycle;
    rst = 1'b0;
    nextCycle;
    waitSample;
    checkOutput("t5 proto_err cleared by reset", 32'(proto_err), 32'd0);
    nextCycle;
    rst = 1'b1;

    // 6) reset with two in flight; state restarts and ch0 wins first
    applyStimulus(2'b01, 1'b1, 1'b0, 32'h0);
    pushAccept(0, ADDR0);
    nextCycle;
    pushAccept(0, ADDR0);
    nextCycle;
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    nextCycle;
    rst = 1'b1;
    waitSample;
    checkOutput("t6 outstanding reset", 32'(outstanding), 32'd0);
    checkOutput("t6 m_req idle", 32'(m_req), 32'd0);
    nextCycle;
    applyStimulus(2'b11, 1'b0, 1'b0, 32'h0);
    waitSample;
    checkOutput("t6 first grant ch0 addr", m_addr, ADDR0);
    checkOutput("t6 m_req", 32'(m_req), 32'd1);
    nextCycle;
    applyStimulus(2'b11, 1'b1, 1'b0, 32'h0);
    pushAccept(0, ADDR0);
    nextCycle;
    applyStimulus(2'b00, 1'b0, 1'b1, 32'hD600_0001);
    pushResp(0, 32'hD600_0001);
    nextCycle;
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
    waitSample;
    checkOutput("t6 outstanding drained", 32'(outstanding), 32'd0);
    checkOutput("t6 proto_err clear", 32'(proto_err), 32'd0);
    nextCycle;

    // Every queued expectation must have been consumed
    repeat (2) nextCycle;
    checkOutput("accept queue drained", 32'(expAcceptQ.size()), 32'd0);
    checkOutput("response queue drained", 32'(expRespQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
